// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared datapath types and constants for the pipeline stages
package cpu_types_pkg;

    localparam int WAIT_CNT_W = 16;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access stage with stall FSM, halt handling and MEM/WB register
module mem_wb_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        valid_in,
    input  logic        WB_MemToReg_in,
    input  logic        WB_RegWrite_in,
    input  logic        M_Branch_in,
    input  logic        M_MemRead_in,
    input  logic        M_MemWrite_in,
    input  logic        alu_zero_in,
    input  logic        halt_in,
    input  logic [31:0] alu_output_in,
    input  logic [31:0] adder_result_in,
    input  logic [31:0] regfile_rdat2_in,
    input  logic [4:0]  reg_dest_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic        mem_stall,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        halt_out,
    output logic        WB_RegWrite_out,
    output logic        WB_MemToReg_out,
    output logic [31:0] wdat_out,
    output logic [4:0]  reg_dest_out,
    output logic [15:0] wait_cycles
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_ONE = WAIT_CNT_W'(1);
    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;

    mem_state_t            state_q, state_d;
    logic                  halt_q, halt_d;
    logic                  regwrite_q, regwrite_d;
    logic                  memtoreg_q, memtoreg_d;
    word_t                 wdat_q, wdat_d;
    regbits_t              dest_q, dest_d;
    logic [WAIT_CNT_W-1:0] wait_q, wait_d;

    logic halted, mem_op, request, retire, read_only;

    // Reset gates the request combinationally so an in-flight access is dropped at once.
    assign halted    = (state_q == HALTED);
    assign mem_op    = valid_in & (M_MemRead_in | M_MemWrite_in) & ~halted;
    assign request   = mem_op & ~RST;
    assign mem_stall = request & ~dhit;
    assign retire    = valid_in & ~mem_stall & ~halted & ~RST;
    assign read_only = M_MemRead_in & ~M_MemWrite_in;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (retire && halt_in) state_d = HALTED;
                else if (mem_stall)    state_d = WAIT;
            end
            WAIT: begin
                if (!mem_stall) state_d = (retire && halt_in) ? HALTED : IDLE;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmemREN       = request & read_only;
        dmemWEN       = request & M_MemWrite_in;
        dmemaddr      = alu_output_in;
        dmemstore     = regfile_rdat2_in;
        pc_src        = retire & M_Branch_in & alu_zero_in;
        branch_target = adder_result_in;
    end

    // Anything that does not retire becomes a bubble in MEM/WB.
    always_comb begin
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        wdat_d     = '0;
        dest_d     = '0;
        if (retire) begin
            regwrite_d = WB_RegWrite_in;
            memtoreg_d = WB_MemToReg_in;
            dest_d     = reg_dest_in;
            wdat_d     = (WB_MemToReg_in && read_only) ? dmemload : alu_output_in;
        end
        halt_d = halt_q | (retire & halt_in);
        wait_d = (mem_stall && wait_q != WAIT_MAX) ? wait_q + WAIT_ONE : wait_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q     <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            wdat_q     <= '0;
            dest_q     <= '0;
            wait_q     <= '0;
        end else begin
            halt_q     <= halt_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            wdat_q     <= wdat_d;
            dest_q     <= dest_d;
            wait_q     <= wait_d;
        end
    end

    assign halt_out        = halt_q;
    assign WB_RegWrite_out = regwrite_q;
    assign WB_MemToReg_out = memtoreg_q;
    assign wdat_out        = wdat_q;
    assign reg_dest_out    = dest_q;
    assign wait_cycles     = wait_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with a transaction-level model
module tb_mem_wb_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        valid_in = 1'b0;
    logic        WB_MemToReg_in = 1'b0, WB_RegWrite_in = 1'b0;
    logic        M_Branch_in = 1'b0, M_MemRead_in = 1'b0, M_MemWrite_in = 1'b0;
    logic        alu_zero_in = 1'b0, halt_in = 1'b0;
    logic [31:0] alu_output_in = '0, adder_result_in = '0, regfile_rdat2_in = '0;
    logic [4:0]  reg_dest_in = '0;
    logic        dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic        dmemREN, dmemWEN, mem_stall, pc_src, halt_out;
    logic        WB_RegWrite_out, WB_MemToReg_out;
    logic [31:0] dmemaddr, dmemstore, branch_target, wdat_out;
    logic [4:0]  reg_dest_out;
    logic [15:0] wait_cycles;

    mem_wb_stage dut (
        .CLK(CLK), .RST(RST), .valid_in(valid_in),
        .WB_MemToReg_in(WB_MemToReg_in), .WB_RegWrite_in(WB_RegWrite_in),
        .M_Branch_in(M_Branch_in), .M_MemRead_in(M_MemRead_in), .M_MemWrite_in(M_MemWrite_in),
        .alu_zero_in(alu_zero_in), .halt_in(halt_in),
        .alu_output_in(alu_output_in), .adder_result_in(adder_result_in),
        .regfile_rdat2_in(regfile_rdat2_in), .reg_dest_in(reg_dest_in),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .pc_src(pc_src), .branch_target(branch_target),
        .halt_out(halt_out), .WB_RegWrite_out(WB_RegWrite_out), .WB_MemToReg_out(WB_MemToReg_out),
        .wdat_out(wdat_out), .reg_dest_out(reg_dest_out), .wait_cycles(wait_cycles)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [4:0]  dest;
        logic [31:0] wdat;
    } wb_t;

    wb_t         sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_wait = '0;
    logic        exp_halt = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: after each edge compare registered outputs with the model.
    initial begin
        wb_t e;
        forever begin
            @(posedge CLK);
            #1;
            chk("wait_cycles", 32'(wait_cycles), 32'(exp_wait));
            chk("halt_out", 32'(halt_out), 32'(exp_halt));
            if (WB_RegWrite_out || WB_MemToReg_out || reg_dest_out != 0 || wdat_out != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_writeback", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("wb_regwrite", 32'(WB_RegWrite_out), 32'(e.rw));
                    chk("wb_memtoreg", 32'(WB_MemToReg_out), 32'(e.m2r));
                    chk("wb_dest", 32'(reg_dest_out), 32'(e.dest));
                    chk("wb_wdat", wdat_out, e.wdat);
                end
            end
        end
    end

    // Drives one instruction until it retires; dhit arrives after 'delay' waiting cycles.
    task automatic run_instr(input logic rd, input logic wr, input logic br, input logic zero,
                             input logic hlt, input logic m2r, input logic rw,
                             input logic [31:0] alu, input logic [31:0] store,
                             input logic [31:0] tgt, input logic [31:0] lval,
                             input logic [4:0] dest, input int delay);
        int   k;
        logic memop, stall, retire;
        wb_t  e;
        k = 0;
        do begin
            @(negedge CLK);
            valid_in = 1'b1;
            M_MemRead_in = rd; M_MemWrite_in = wr; M_Branch_in = br; alu_zero_in = zero;
            halt_in = hlt; WB_MemToReg_in = m2r; WB_RegWrite_in = rw;
            alu_output_in = alu; regfile_rdat2_in = store; adder_result_in = tgt;
            reg_dest_in = dest;
            dhit = (k >= delay);
            dmemload = (k >= delay) ? lval : $urandom;
            memop  = (rd | wr) & ~exp_halt;
            stall  = memop & (k < delay);
            retire = ~stall & ~exp_halt;
            #1;
            chk("mem_stall", 32'(mem_stall), 32'(stall));
            chk("dmemREN", 32'(dmemREN), 32'(memop & rd & ~wr));
            chk("dmemWEN", 32'(dmemWEN), 32'(memop & wr));
            if (memop) begin
                chk("dmemaddr", dmemaddr, alu);
                chk("dmemstore", dmemstore, store);
            end
            chk("pc_src", 32'(pc_src), 32'(retire & br & zero));
            chk("branch_target", branch_target, tgt);
            if (stall && exp_wait != 16'hFFFF) exp_wait = exp_wait + 16'd1;
            if (retire) begin
                e.rw = rw; e.m2r = m2r; e.dest = dest;
                e.wdat = (m2r && rd && !wr) ? lval : alu;
                sb.push_back(e);
                if (hlt) exp_halt = 1'b1;
            end
            k++;
        end while (stall);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            valid_in = 1'b0; dhit = 1'b0;
            #1;
            chk("idle_stall", 32'(mem_stall), 32'd0);
            chk("idle_pc_src", 32'(pc_src), 32'd0);
        end
    endtask

    task automatic pulse_reset(input logic keep_valid);
        @(negedge CLK);
        RST = 1'b1;
        if (!keep_valid) valid_in = 1'b0;
        dhit = 1'b0;
        exp_wait = '0;
        exp_halt = 1'b0;
        sb.delete();
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_ren", 32'(dmemREN), 32'd0);
        chk("rst_wen", 32'(dmemWEN), 32'd0);
        chk("rst_halt", 32'(halt_out), 32'd0);
        chk("rst_wait", 32'(wait_cycles), 32'd0);
        chk("rst_regwrite", 32'(WB_RegWrite_out), 32'd0);
        chk("rst_wdat", wdat_out, 32'd0);
        chk("rst_dest", 32'(reg_dest_out), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        valid_in = 1'b0;
    endtask

    initial begin
        logic rd, wr;
        pulse_reset(1'b0);

        run_instr(1, 0, 0, 0, 0, 1, 1, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd3, 3);
        @(posedge CLK); #2;
        chk("load_wait_cycles", 32'(wait_cycles), 32'd3);
        chk("load_wdat", wdat_out, 32'hDEADBEEF);
        chk("load_regwrite", 32'(WB_RegWrite_out), 32'd1);

        run_instr(0, 1, 0, 0, 0, 0, 0, 32'h40, 32'h1234, 32'h0, 32'h0, 5'd7, 0);
        idle(1);
        run_instr(0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h0, 5'd1, 0);
        run_instr(0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h200, 32'h0, 5'd1, 0);
        run_instr(1, 1, 0, 0, 0, 1, 1, 32'h55, 32'h66, 32'h0, 32'h77, 5'd9, 1);

        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom);
            wr = 1'($urandom);
            run_instr(rd, wr, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 1'($urandom),
                      $urandom, $urandom, $urandom, $urandom,
                      5'($urandom_range(1, 31)), $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        run_instr(1, 0, 0, 0, 1, 1, 1, 32'h300, 32'h0, 32'h0, 32'hCAFE0001, 5'd4, 2);
        idle(2);
        run_instr(1, 0, 0, 0, 0, 1, 1, 32'h304, 32'h0, 32'h0, 32'h1, 5'd5, 2);
        pulse_reset(1'b0);

        run_instr(0, 0, 0, 0, 1, 0, 1, 32'hABC, 32'h0, 32'h0, 32'h0, 5'd2, 0);
        idle(3);
        run_instr(1, 0, 0, 0, 0, 1, 1, 32'h500, 32'h0, 32'h0, 32'h9, 5'd6, 1);
        chk("halted_halt_out", 32'(halt_out), 32'd1);
        pulse_reset(1'b0);

        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            valid_in = 1'b1; M_MemRead_in = 1'b1; M_MemWrite_in = 1'b0; M_Branch_in = 1'b0;
            halt_in = 1'b0; WB_MemToReg_in = 1'b1; WB_RegWrite_in = 1'b1;
            alu_output_in = 32'h600; reg_dest_in = 5'd8; dhit = 1'b0;
            #1;
            chk("pre_rst_stall", 32'(mem_stall), 32'd1);
            exp_wait = exp_wait + 16'd1;
        end
        pulse_reset(1'b1);
        idle(3);

        run_instr(1, 0, 0, 0, 0, 1, 1, 32'h700, 32'h0, 32'h0, 32'h12345678, 5'd10, 65600);
        chk("sat_wait_cycles", 32'(wait_cycles), 32'hFFFF);
        idle(3);
        chk("sat_hold", 32'(wait_cycles), 32'hFFFF);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
